hilo_muldiv: RTL

Multiply/divide sequencer and HI/LO register file for the MIPS execute stage. Sits directly upstream of the two-stage Booth/Wallace multiplier `mul`:
- registers the operands and drives them into `mul`;
- waits out its pipeline latency and writes the 64-bit product into HI/LO.

It also performs DIV/DIVU with an iterative divider and handles MTHI/MTLO. It exposes a valid/ready handshake so the pipeline stalls while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/div_iter.sv | 74 +++++++
 rtl/hilo_muldiv.sv | 130 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared op codes, sequencer state encoding and divider constants for hilo_muldiv.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_MUL_ISSUE = 2'd1;
    localparam logic [1:0] ST_MUL_WB    = 2'd2;
    localparam logic [1:0] ST_DIV       = 2'd3;

    // Tied to the 32-bit datapath: one quotient bit per iteration.
    localparam int DIV_CYCLES = 32;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring radix-2 divider, one quotient bit per cycle over DIV_CYCLES cycles.
// quotient/remainder are combinational and sign-fixed, valid in the cycle 'last' is high.
module div_iter
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        last,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [4:0]  cnt;
    logic [31:0] dvs;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        neg_q;
    logic        neg_r;

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        qbit;
    logic [31:0] quo_nxt;
    logic [31:0] rem_nxt;

    // The dividend shifts out of quo from the top while quotient bits shift in below.
    always_comb begin
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, dvs};
        qbit    = ~diff[32];
        rem_nxt = qbit ? diff[31:0] : shifted[31:0];
        quo_nxt = {quo[30:0], qbit};
    end

    assign last      = busy && (cnt == 5'(DIV_CYCLES - 1));
    assign quotient  = neg_q ? (~quo_nxt + 32'd1) : quo_nxt;
    assign remainder = neg_r ? (~rem_nxt + 32'd1) : rem_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= 1'b0;
            cnt   <= 5'd0;
            dvs   <= 32'd0;
            quo   <= 32'd0;
            rem   <= 32'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= 5'd0;
            dvs   <= magnitude(b, is_signed);
            quo   <= magnitude(a, is_signed);
            rem   <= 32'd0;
            neg_q <= is_signed && (a[31] ^ b[31]);
            neg_r <= is_signed && a[31];
        end else if (busy) begin
            if (cancel || last) begin
                busy <= 1'b0;
            end
            if (!cancel) begin
                quo <= quo_nxt;
                rem <= rem_nxt;
                cnt <= cnt + 5'd1;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register file and mul/div sequencer; MUL done at cycle 3, DIV at 33, MTHI/MTLO at 1.
// op_ready only in IDLE; divider built when HILO_DIV_EN is defined, else DIV/DIVU are no-ops.
module hilo_muldiv
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mul_signed,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    input  logic [63:0] mul_result
);

    logic [1:0] state;
    logic       accept;

    assign op_ready = (state == ST_IDLE);
    assign accept   = op_valid && op_ready && !cancel;

`ifdef HILO_DIV_EN
    logic        div_start;
    logic        div_busy;
    logic        div_last;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        div_zero;

    assign div_start = accept && ((op == OP_DIV) || (op == OP_DIVU));

    div_iter u_div_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .is_signed (op == OP_DIV),
        .a         (src_a),
        .b         (src_b),
        .cancel    (cancel),
        .busy      (div_busy),
        .last      (div_last),
        .quotient  (div_q),
        .remainder (div_r)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            hi         <= 32'd0;
            lo         <= 32'd0;
            done       <= 1'b0;
            mul_signed <= 1'b0;
            mul_x      <= 32'd0;
            mul_y      <= 32'd0;
`ifdef HILO_DIV_EN
            div_zero   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MTHI: begin
                                hi   <= src_a;
                                done <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo   <= src_a;
                                done <= 1'b1;
                            end
                            OP_MULT, OP_MULTU: begin
                                mul_x      <= src_a;
                                mul_y      <= src_b;
                                mul_signed <= (op == OP_MULT);
                                state      <= ST_MUL_ISSUE;
                            end
                            OP_DIV, OP_DIVU: begin
`ifdef HILO_DIV_EN
                                div_zero <= (src_b == 32'd0);
                                state    <= ST_DIV;
`else
                                done     <= 1'b1;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL_ISSUE: begin
                    state <= cancel ? ST_IDLE : ST_MUL_WB;
                end
                ST_MUL_WB: begin
                    state <= ST_IDLE;
                    if (!cancel) begin
                        {hi, lo} <= mul_result;
                        done     <= 1'b1;
                    end
                end
`ifdef HILO_DIV_EN
                ST_DIV: begin
                    if (cancel) begin
                        state <= ST_IDLE;
                    end else if (div_last) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                        // Division by zero completes normally but leaves HI/LO alone.
                        if (!div_zero) begin
                            hi <= div_r;
                            lo <= div_q;
                        end
                    end else if (!div_busy) begin
                        state <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
